// File: rtl/mem_stage_wait_if.sv
// EX/MEM -> MEM/WB handshake bundle for mem_stage_wait.
// Upstream drives through master; the stage itself connects through slave.
interface mem_stage_wait_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
);
    logic              in_valid;
    logic              IRegWrite;
    logic              IRegStore;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] IALUResult;
    logic [DATA_W-1:0] thirdArg;
    logic [RD_W-1:0]   rdMem;
    logic              flush;

    logic              stall;
    logic              out_valid;
    logic              ORegWrite;
    logic              ORegStore;
    logic [DATA_W-1:0] OALUResult;
    logic [DATA_W-1:0] OMemData;
    logic [RD_W-1:0]   rdWB;

    modport master (
        output in_valid, IRegWrite, IRegStore, MemWrite, MemRead,
               IALUResult, thirdArg, rdMem, flush,
        input  stall, out_valid, ORegWrite, ORegStore, OALUResult, OMemData, rdWB
    );

    modport slave (
        input  in_valid, IRegWrite, IRegStore, MemWrite, MemRead,
               IALUResult, thirdArg, rdMem, flush,
        output stall, out_valid, ORegWrite, ORegStore, OALUResult, OMemData, rdWB
    );
endinterface

// File: rtl/mem_stage_wait.sv
// Pipeline MEM stage with a fixed-wait-state data RAM: memory ops stall
// upstream for WAIT cycles, then complete from the captured operation.
module mem_stage_wait #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input logic          clk,
    input logic          reset,
    mem_stage_wait_if.slave bus
);
    typedef enum logic {RUN, BUSY} state_e;

    typedef struct packed {
        logic              reg_write;
        logic              reg_store;
        logic              mem_write;
        logic              mem_read;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } op_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              reg_store;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem_data;
        logic [RD_W-1:0]   rd;
    } wb_t;

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);
    localparam bit         HAS_WAIT = (WAIT > 0);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    op_t               hold_q, hold_d;
    wb_t               wb_q, wb_d;
    op_t               op_in, src;
    logic              fire;
    logic              mem_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_comb begin
        op_in.reg_write = bus.IRegWrite;
        op_in.reg_store = bus.IRegStore;
        op_in.mem_write = bus.MemWrite;
        op_in.mem_read  = bus.MemRead;
        op_in.alu       = bus.IALUResult;
        op_in.data      = bus.thirdArg;
        op_in.rd        = bus.rdMem;
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        src     = op_in;
        fire    = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.in_valid) begin
                    if (HAS_WAIT && (op_in.mem_write || op_in.mem_read)) begin
                        hold_d  = op_in;
                        cnt_d   = WAIT_CNT;
                        state_d = BUSY;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            BUSY: begin
                src = hold_q;
                if (cnt_q > 3'd1) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // A squash beats both a fresh accept and a completing access.
        if (bus.flush) begin
            fire    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    assign addr    = src.alu[ADDR_W-1:0];
    assign rd_data = mem_q[addr];
    assign mem_we  = fire && src.mem_write;

    always_comb begin
        wb_d = '0;
        if (fire) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_write = src.reg_write;
            wb_d.reg_store = src.reg_store;
            wb_d.alu       = src.alu;
            wb_d.rd        = src.rd;
            // Read-before-write: a combined read/write returns the old word.
            wb_d.mem_data  = src.mem_read ? rd_data : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            hold_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            wb_q    <= wb_d;
        end
    end

    // NOTE: the RAM has no reset; its contents survive reset and map onto plain memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr] <= src.data;
        end
    end

    assign bus.stall      = (state_q == BUSY);
    assign bus.out_valid  = wb_q.valid;
    assign bus.ORegWrite  = wb_q.reg_write & wb_q.valid;
    assign bus.ORegStore  = wb_q.reg_store & wb_q.valid;
    assign bus.OALUResult = wb_q.alu;
    assign bus.OMemData   = wb_q.mem_data;
    assign bus.rdWB       = wb_q.rd;
endmodule

// File: tb/tb_mem_stage_wait.sv
// Self-checking bench for mem_stage_wait: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_stage_wait;
    localparam int DATA_W = 16;
    localparam int RD_W   = 3;
    localparam int ADDR_W = 8;
    localparam int WAIT   = 2;

    typedef struct {
        logic        rw, rs, mw, mr;
        logic [15:0] alu, data;
        logic [2:0]  rd;
    } op_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_stage_wait_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    mem_stage_wait #(
        .DATA_W(DATA_W), .RD_W(RD_W), .ADDR_W(ADDR_W), .WAIT(WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an op either completes at the edge it is
    // accepted, or is parked and completes WAIT edges after acceptance.
    logic [15:0] mdl_mem [256];
    bit          pend    = 1'b0;
    op_t         pend_op;
    int          cyc     = 0;
    int          done_at = 0;
    logic        exp_valid = 0, exp_rw = 0, exp_rs = 0, exp_stall = 0;
    logic [15:0] exp_alu = 0, exp_md = 0;
    logic [2:0]  exp_rd = 0;

    function automatic void bubble();
        exp_valid = 0; exp_rw = 0; exp_rs = 0;
        exp_alu = 0; exp_md = 0; exp_rd = 0;
    endfunction

    function automatic void complete(input op_t op);
        logic [7:0] a;
        a = op.alu[7:0];
        exp_valid = 1'b1;
        exp_rw    = op.rw;
        exp_rs    = op.rs;
        exp_alu   = op.alu;
        exp_rd    = op.rd;
        exp_md    = op.mr ? mdl_mem[a] : 16'h0;
        if (op.mw) mdl_mem[a] = op.data;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble();
            pend      = 1'b0;
            exp_stall = 1'b0;
        end else begin
            op_t cur;
            cyc++;
            bubble();
            cur.rw = bus.IRegWrite; cur.rs = bus.IRegStore;
            cur.mw = bus.MemWrite;  cur.mr = bus.MemRead;
            cur.alu = bus.IALUResult; cur.data = bus.thirdArg; cur.rd = bus.rdMem;
            if (bus.flush) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cyc == done_at) begin
                    complete(pend_op);
                    pend = 1'b0;
                end
            end else if (bus.in_valid) begin
                if ((cur.mw || cur.mr) && WAIT > 0) begin
                    pend    = 1'b1;
                    pend_op = cur;
                    done_at = cyc + WAIT;
                end else begin
                    complete(cur);
                end
            end
            exp_stall = pend;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_out_valid", bus.out_valid, exp_valid);
            check("m_ORegWrite", bus.ORegWrite, exp_rw);
            check("m_ORegStore", bus.ORegStore, exp_rs);
            check("m_OALUResult", bus.OALUResult, exp_alu);
            check("m_OMemData", bus.OMemData, exp_md);
            check("m_rdWB", bus.rdWB, exp_rd);
            check("m_stall", bus.stall, exp_stall);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic rs, input logic mw,
                         input logic mr, input logic [15:0] alu, input logic [15:0] data,
                         input logic [2:0] rd, input logic fl);
        bus.in_valid = v;  bus.IRegWrite = rw; bus.IRegStore = rs;
        bus.MemWrite = mw; bus.MemRead = mr;   bus.IALUResult = alu;
        bus.thirdArg = data; bus.rdMem = rd;   bus.flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_ORegWrite"}, bus.ORegWrite, 0);
        check({tag, "_OALUResult"}, bus.OALUResult, 0);
        check({tag, "_OMemData"}, bus.OMemData, 0);
        check({tag, "_rdWB"}, bus.rdWB, 0);
        check({tag, "_stall"}, bus.stall, 0);
    endtask

    initial begin
        cmp_en = 1'b1;
        // Reset with live-looking inputs
        drive(1, 1, 0, 0, 0, 16'h0004, 16'hAAAA, 3'd5, 0);
        #1 check_all_zero("rst_t0");
        repeat (2) step();
        check_all_zero("rst_held");
        reset = 1'b1;

        // ALU pass-through, latency 1
        drive(1, 1, 0, 0, 0, 16'h1234, 16'h0, 3'd3, 0);
        step();
        check("alu_out_valid", bus.out_valid, 1);
        check("alu_OALUResult", bus.OALUResult, 16'h1234);
        check("alu_rdWB", bus.rdWB, 3);
        check("alu_ORegWrite", bus.ORegWrite, 1);
        check("alu_stall", bus.stall, 0);
        idle();

        // Store with two wait states
        drive(1, 0, 0, 1, 0, 16'h0004, 16'hAAAA, 3'd0, 0);
        step();
        check("st_stall1", bus.stall, 1);
        check("st_valid1", bus.out_valid, 0);
        idle();
        step();
        check("st_stall2", bus.stall, 1);
        check("st_valid2", bus.out_valid, 0);
        step();
        check("st_valid3", bus.out_valid, 1);
        check("st_stall3", bus.stall, 0);
        check("st_OMemData", bus.OMemData, 0);

        // Load with address wrap-around
        drive(1, 1, 0, 0, 1, 16'h0104, 16'h0, 3'd2, 0);
        step(); idle(); step(); step();
        check("ld_out_valid", bus.out_valid, 1);
        check("ld_OMemData", bus.OMemData, 16'hAAAA);
        check("ld_OALUResult", bus.OALUResult, 16'h0104);
        check("ld_rdWB", bus.rdWB, 2);

        // Flush in the first BUSY cycle kills the store
        drive(1, 0, 0, 1, 0, 16'h0004, 16'h5555, 3'd0, 0);
        step();
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 1);
        step();
        check("fl_valid1", bus.out_valid, 0);
        check("fl_stall", bus.stall, 0);
        idle();
        step();
        check("fl_valid2", bus.out_valid, 0);
        drive(1, 1, 0, 0, 1, 16'h0004, 16'h0, 3'd1, 0);
        step(); idle(); step(); step();
        check("fl_reload", bus.OMemData, 16'hAAAA);

        // Seed address 8, then reset in the 2nd BUSY cycle of an overwrite
        drive(1, 0, 0, 1, 0, 16'h0008, 16'h2222, 3'd0, 0);
        step(); idle(); step(); step();
        check("seed_valid", bus.out_valid, 1);
        drive(1, 0, 0, 1, 0, 16'h0008, 16'h1111, 3'd0, 0);
        step(); idle(); step();
        check("mr_stall_pre", bus.stall, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("mr_async");
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1, 1, 1, 0, 0, 16'h00FF, 16'h0, 3'd7, 0);
        step();
        check("mr_pt_valid", bus.out_valid, 1);
        check("mr_pt_ORegStore", bus.ORegStore, 1);
        check("mr_pt_OALUResult", bus.OALUResult, 16'h00FF);
        check("mr_pt_rdWB", bus.rdWB, 7);
        drive(1, 1, 0, 0, 1, 16'h0008, 16'h0, 3'd4, 0);
        step(); idle(); step(); step();
        check("mr_no_write", bus.OMemData, 16'h2222);

        // Randomized traffic over a pre-initialised 16-word window
        for (int a = 0; a < 16; a++) begin
            drive(1, 0, 0, 1, 0, {8'($urandom), 8'(a)}, 16'($urandom), 3'd0, 0);
            step(); idle(); step(); step();
        end
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 5) != 0, 1'($urandom), 1'($urandom),
                  ($urandom % 3) == 0, ($urandom % 3) == 0,
                  {8'($urandom), 4'h0, 4'($urandom)}, 16'($urandom),
                  3'($urandom), ($urandom % 20) == 0);
            step();
        end
        idle();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
